// File: rtl/reset_seq_pkg.sv
// Shared constants, state encoding and width helper for the reset release sequencer.
package reset_seq_pkg;

  // Default build parameters.
  localparam int unsigned DEF_N_STAGES    = 3;
  localparam int unsigned DEF_SYNC_DEPTH  = 3;
  localparam int unsigned DEF_HOLD_CYCLES = 4;
  localparam int unsigned DEF_TIMEOUT     = 255;

  // Sequencer state encoding.
  typedef logic [2:0] state_t;
  localparam state_t ST_HOLD    = 3'd0;
  localparam state_t ST_RELEASE = 3'd1;
  localparam state_t ST_WAIT    = 3'd2;
  localparam state_t ST_DONE    = 3'd3;
  localparam state_t ST_FAULT   = 3'd4;

  // ceil(log2(v)), never less than 1 so every derived vector is at least one bit wide.
  function automatic int unsigned clog2_min1(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/reset_sync_chain.sv
// Ready-acknowledge synchronizer: DEPTH-flop shift register, synchronously cleared.
module reset_sync_chain
  import reset_seq_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_SYNC_DEPTH
) (
  input  logic clk,
  input  logic clear,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] sync_q;
  logic [DEPTH-1:0] sync_d;

  // Shift the raw ready in at bit 0; the oldest sample leaves at the top.
  always_comb begin
    sync_d = {sync_q[DEPTH-2:0], d};
  end

  // Chain register with synchronous clear.
  always_ff @(posedge clk) begin
    if (clear) sync_q <= '0;
    else       sync_q <= sync_d;
  end

  assign q = sync_q[DEPTH-1];

endmodule

// File: rtl/reset_release_sequencer.sv
// Releases per-domain resets one stage at a time, waiting on each stage's synchronized ready.
module reset_release_sequencer
  import reset_seq_pkg::*;
#(
  parameter  int unsigned N_STAGES    = DEF_N_STAGES,
  parameter  int unsigned SYNC_DEPTH  = DEF_SYNC_DEPTH,
  parameter  int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter  int unsigned TIMEOUT     = DEF_TIMEOUT,
  localparam int unsigned IDX_W       = clog2_min1(N_STAGES)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                io_swReq,
  input  logic [N_STAGES-1:0] io_stageReady,
  output logic [N_STAGES-1:0] io_stageReset,
  output logic                io_busy,
  output logic                io_done,
  output logic                io_timeout,
  output logic [IDX_W-1:0]    io_stageIdx
);

  localparam int unsigned CNT_MAX = (HOLD_CYCLES > TIMEOUT) ? HOLD_CYCLES : TIMEOUT;
  localparam int unsigned CNT_W   = clog2_min1(CNT_MAX + 1);

  logic [N_STAGES-1:0] rdy_s;

  state_t              state_q,    state_d;
  logic [CNT_W-1:0]    hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0]    to_cnt_q,   to_cnt_d;
  logic [IDX_W-1:0]    idx_q,      idx_d;
  logic [N_STAGES-1:0] rst_q,      rst_d;
  logic                busy_q,     busy_d;
  logic                done_q,     done_d;
  logic                timeout_q,  timeout_d;

  // One synchronizer per ready acknowledge; cleared together with the block.
  for (genvar g = 0; g < N_STAGES; g++) begin : g_sync
    reset_sync_chain #(
      .DEPTH (SYNC_DEPTH)
    ) u_sync (
      .clk   (clk),
      .clear (reset),
      .d     (io_stageReady[g]),
      .q     (rdy_s[g])
    );
  end

  // Next-state, counter and output-register decode.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    to_cnt_d   = to_cnt_q;
    idx_d      = idx_q;
    rst_d      = rst_q;
    timeout_d  = timeout_q;

    case (state_q)
      ST_HOLD: begin
        rst_d = '1;
        if (hold_cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
          state_d    = ST_RELEASE;
          idx_d      = '0;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end
      ST_RELEASE: begin
        rst_d[idx_q] = 1'b0;
        to_cnt_d     = '0;
        state_d      = ST_WAIT;
      end
      ST_WAIT: begin
        // A ready seen on the last count still wins over the timeout.
        if (rdy_s[idx_q]) begin
          if (idx_q == IDX_W'(N_STAGES - 1)) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = ST_RELEASE;
          end
        end else if (to_cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d   = ST_FAULT;
          timeout_d = 1'b1;
          rst_d     = '1;
        end else begin
          to_cnt_d = to_cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        rst_d = '0;
      end
      ST_FAULT: begin
        rst_d = '1;
      end
      default: begin
        state_d = ST_HOLD;
        rst_d   = '1;
      end
    endcase

    // Software re-sequence overrides everything and restarts from HOLD.
    if (io_swReq) begin
      state_d    = ST_HOLD;
      hold_cnt_d = '0;
      to_cnt_d   = '0;
      idx_d      = '0;
      rst_d      = '1;
      timeout_d  = 1'b0;
    end

    busy_d = (state_d == ST_HOLD) || (state_d == ST_RELEASE) || (state_d == ST_WAIT);
    done_d = (state_d == ST_DONE);
  end

  // State, counters and registered outputs; block reset forces the held state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_HOLD;
      hold_cnt_q <= '0;
      to_cnt_q   <= '0;
      idx_q      <= '0;
      rst_q      <= '1;
      busy_q     <= 1'b1;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      to_cnt_q   <= to_cnt_d;
      idx_q      <= idx_d;
      rst_q      <= rst_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
    end
  end

  assign io_stageReset = rst_q;
  assign io_busy       = busy_q;
  assign io_done       = done_q;
  assign io_timeout    = timeout_q;
  assign io_stageIdx   = idx_q;

endmodule

// File: tb/tb_reset_release_sequencer.sv
// Directed bench for reset_release_sequencer (3 stages, sync depth 3, hold 4, timeout 16).
module tb_reset_release_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       sw_req;
  logic [2:0] ready;
  logic [2:0] stage_reset;
  logic       busy;
  logic       done;
  logic       timeout;
  logic [1:0] stage_idx;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int base     = 0;

  always #5 clk = ~clk;

  reset_release_sequencer #(
    .N_STAGES    (3),
    .SYNC_DEPTH  (3),
    .HOLD_CYCLES (4),
    .TIMEOUT     (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .io_swReq      (sw_req),
    .io_stageReady (ready),
    .io_stageReset (stage_reset),
    .io_busy       (busy),
    .io_done       (done),
    .io_timeout    (timeout),
    .io_stageIdx   (stage_idx)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int k);
    while (cyc < k) tick();
  endtask

  // Reset for two edges, then cycle 0 is the first cycle with reset low.
  task automatic do_reset(input logic [2:0] rdy);
    reset  = 1'b1;
    sw_req = 1'b0;
    ready  = rdy;
    tick();
    tick();
    reset = 1'b0;
    cyc   = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values held for 5 cycles.
    reset  = 1'b1;
    sw_req = 1'b0;
    ready  = 3'b111;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rst_stage_reset", 32'(stage_reset), 32'h7);
      chk("rst_busy",        32'(busy),        32'h1);
      chk("rst_done",        32'(done),        32'h0);
      chk("rst_timeout",     32'(timeout),     32'h0);
      chk("rst_idx",         32'(stage_idx),   32'h0);
    end
    reset = 1'b0;
    cyc   = 0;

    // Normal release with all readies high.
    for (int k = 0; k <= 12; k++) begin
      logic [2:0] exp_rst;
      run_to(k);
      exp_rst = (k < 5) ? 3'b111 : (k < 7) ? 3'b110 : (k < 9) ? 3'b100 : 3'b000;
      chk("norm_stage_reset", 32'(stage_reset), 32'(exp_rst));
      chk("norm_done",        32'(done),        (k >= 10) ? 32'h1 : 32'h0);
      chk("norm_busy",        32'(busy),        (k >= 10) ? 32'h0 : 32'h1);
      if (k == 7) chk("norm_idx1", 32'(stage_idx), 32'h1);
      if (k == 9) chk("norm_idx2", 32'(stage_idx), 32'h2);
    end

    // Timeout on stage 1: WAIT entered at cycle 7, FAULT at cycle 23.
    do_reset(3'b101);
    run_to(22);
    chk("to_pre_stage_reset", 32'(stage_reset), 32'h4);
    chk("to_pre_timeout",     32'(timeout),     32'h0);
    chk("to_pre_busy",        32'(busy),        32'h1);
    chk("to_pre_idx",         32'(stage_idx),   32'h1);
    run_to(23);
    chk("to_stage_reset", 32'(stage_reset), 32'h7);
    chk("to_timeout",     32'(timeout),     32'h1);
    chk("to_busy",        32'(busy),        32'h0);
    chk("to_done",        32'(done),        32'h0);
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("fault_hold_timeout",     32'(timeout),     32'h1);
      chk("fault_hold_stage_reset", 32'(stage_reset), 32'h7);
    end

    // Recovery from FAULT via software request.
    sw_req = 1'b1;
    ready  = 3'b111;
    tick();
    sw_req = 1'b0;
    base   = cyc;
    chk("rec_timeout",     32'(timeout),     32'h0);
    chk("rec_stage_reset", 32'(stage_reset), 32'h7);
    chk("rec_busy",        32'(busy),        32'h1);
    chk("rec_idx",         32'(stage_idx),   32'h0);
    run_to(base + 5);
    chk("rec_first_release", 32'(stage_reset), 32'h6);
    run_to(base + 9);
    chk("rec_done_pre", 32'(done), 32'h0);
    run_to(base + 10);
    chk("rec_done",        32'(done),        32'h1);
    chk("rec_done_resets", 32'(stage_reset), 32'h0);

    // Software request while waiting on stage 2.
    do_reset(3'b011);
    run_to(12);
    chk("sw_wait_idx",         32'(stage_idx),   32'h2);
    chk("sw_wait_stage_reset", 32'(stage_reset), 32'h0);
    chk("sw_wait_busy",        32'(busy),        32'h1);
    sw_req = 1'b1;
    ready  = 3'b111;
    tick();
    sw_req = 1'b0;
    base   = cyc;
    chk("sw_stage_reset", 32'(stage_reset), 32'h7);
    chk("sw_idx",         32'(stage_idx),   32'h0);
    chk("sw_busy",        32'(busy),        32'h1);
    run_to(base + 5);
    chk("sw_restart_release", 32'(stage_reset), 32'h6);
    run_to(base + 10);
    chk("sw_restart_done", 32'(done), 32'h1);

    // Block reset asserted while waiting on stage 2.
    ready  = 3'b011;
    sw_req = 1'b1;
    tick();
    sw_req = 1'b0;
    base   = cyc;
    run_to(base + 11);
    chk("mid_wait_busy", 32'(busy),      32'h1);
    chk("mid_wait_idx",  32'(stage_idx), 32'h2);
    reset = 1'b1;
    tick();
    chk("mid_rst_stage_reset", 32'(stage_reset), 32'h7);
    chk("mid_rst_busy",        32'(busy),        32'h1);
    chk("mid_rst_done",        32'(done),        32'h0);
    chk("mid_rst_timeout",     32'(timeout),     32'h0);
    chk("mid_rst_idx",         32'(stage_idx),   32'h0);
    reset = 1'b0;
    ready = 3'b111;
    cyc   = 0;
    run_to(5);
    chk("mid_rst_release", 32'(stage_reset), 32'h6);
    run_to(10);
    chk("mid_rst_done_end", 32'(done), 32'h1);

    // Ready reaching the synchronizer output on the last timeout count wins.
    do_reset(3'b011);
    run_to(21);
    ready = 3'b111;
    run_to(23);
    chk("race_pre_done",    32'(done),    32'h0);
    chk("race_pre_timeout", 32'(timeout), 32'h0);
    run_to(24);
    chk("race_last_timeout", 32'(timeout),   32'h0);
    chk("race_last_busy",    32'(busy),      32'h1);
    chk("race_last_idx",     32'(stage_idx), 32'h2);
    run_to(25);
    chk("race_done",        32'(done),        32'h1);
    chk("race_timeout",     32'(timeout),     32'h0);
    chk("race_stage_reset", 32'(stage_reset), 32'h0);

    // One cycle later the timeout wins instead.
    do_reset(3'b011);
    run_to(22);
    ready = 3'b111;
    run_to(24);
    chk("late_pre_timeout", 32'(timeout), 32'h0);
    run_to(25);
    chk("late_timeout",     32'(timeout),     32'h1);
    chk("late_stage_reset", 32'(stage_reset), 32'h7);
    chk("late_done",        32'(done),        32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
